// File: rtl/pd_pkg.sv
// rtl/pd_pkg.sv - power-domain sequencer states, default timing and per-state output decode
package pd_pkg;

  localparam int unsigned ISO_SETUP_CYC_DEF  = 4;
  localparam int unsigned PWR_SETTLE_CYC_DEF = 8;
  localparam int unsigned TIMEOUT_CYC_DEF    = 64;

  typedef enum logic [2:0] {
    OFF,
    PWR_UP,
    SETTLE,
    ON,
    ISO,
    PWR_DN
  } pd_state_e;

  typedef struct packed {
    logic iso_en;
    logic pwr_sw_en;
    logic pwr_ack;
    logic busy;
  } pd_out_t;

  // Clamp is released only in ON; every other state keeps the crossing forced low.
  function automatic pd_out_t pd_state_outputs(input pd_state_e s);
    pd_out_t o;
    case (s)
      PWR_UP:  o = '{iso_en: 1'b1, pwr_sw_en: 1'b1, pwr_ack: 1'b1, busy: 1'b1};
      SETTLE:  o = '{iso_en: 1'b1, pwr_sw_en: 1'b1, pwr_ack: 1'b1, busy: 1'b1};
      ON:      o = '{iso_en: 1'b0, pwr_sw_en: 1'b1, pwr_ack: 1'b0, busy: 1'b0};
      ISO:     o = '{iso_en: 1'b1, pwr_sw_en: 1'b1, pwr_ack: 1'b0, busy: 1'b1};
      PWR_DN:  o = '{iso_en: 1'b1, pwr_sw_en: 1'b0, pwr_ack: 1'b0, busy: 1'b1};
      default: o = '{iso_en: 1'b1, pwr_sw_en: 1'b0, pwr_ack: 1'b1, busy: 1'b0};
    endcase
    return o;
  endfunction

  function automatic int unsigned pd_max3(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pd_sync_2ff.sv
// rtl/pd_sync_2ff.sv - two-flop synchronizer for always-on inputs, async active-low reset to 0
module pd_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pd_iso_sequencer.sv
// rtl/pd_iso_sequencer.sv - clamp/switch sequencer for one switchable power domain
module pd_iso_sequencer
  import pd_pkg::*;
#(
  parameter int unsigned ISO_SETUP_CYC  = ISO_SETUP_CYC_DEF,
  parameter int unsigned PWR_SETTLE_CYC = PWR_SETTLE_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC    = TIMEOUT_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwr_down_req_i,
  input  logic pwr_good_i,
  input  logic err_clr_i,
  output logic iso_en_o,
  output logic pwr_sw_en_o,
  output logic pwr_ack_o,
  output logic busy_o,
  output logic err_o
);

  localparam int unsigned TMR_MAX = pd_max3(ISO_SETUP_CYC, PWR_SETTLE_CYC, TIMEOUT_CYC);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] ISO_LAST    = TMR_W'(ISO_SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(PWR_SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT_CYC - 1);

  logic             pg_s;
  pd_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d, err_set;
  pd_out_t          out_q, out_d;

  pd_sync_2ff #(
    .WIDTH(1)
  ) u_pg_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (pwr_good_i),
    .q_o   (pg_s)
  );

  // Requests are only looked at in ON/OFF, so a started sequence always runs to completion.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      OFF: begin
        if (!pwr_down_req_i && !err_q) state_d = PWR_UP;
      end
      PWR_UP: begin
        if (pg_s) begin
          state_d = SETTLE;
        end else if (timer_q == TMO_LAST) begin
          state_d = OFF;
          err_set = 1'b1;
        end
      end
      SETTLE: begin
        if (timer_q == SETTLE_LAST) state_d = ON;
      end
      ON: begin
        if (!pg_s) begin
          state_d = PWR_DN;
          err_set = 1'b1;
        end else if (pwr_down_req_i) begin
          state_d = ISO;
        end
      end
      ISO: begin
        if (timer_q == ISO_LAST) state_d = PWR_DN;
      end
      PWR_DN: begin
        if (!pg_s) begin
          state_d = OFF;
        end else if (timer_q == TMO_LAST) begin
          state_d = OFF;
          err_set = 1'b1;
        end
      end
      default: state_d = OFF;
    endcase
  end

  assign timer_d = (state_d != state_q) ? '0 :
                   (timer_q == '1)      ? timer_q : timer_q + 1'b1;
  assign err_d   = err_set | (err_q & ~err_clr_i);
  assign out_d   = pd_state_outputs(state_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OFF;
      timer_q <= '0;
      err_q   <= 1'b0;
      out_q   <= pd_state_outputs(OFF);
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign iso_en_o    = out_q.iso_en;
  assign pwr_sw_en_o = out_q.pwr_sw_en;
  assign pwr_ack_o   = out_q.pwr_ack;
  assign busy_o      = out_q.busy;
  assign err_o       = err_q;

endmodule
